jtgng_spi_dload_tx: RTL and testbench

JTGNG_SPI_DLOAD_TX -- requirements
Module: jtgng_spi_dload_tx

---
 rtl/jtgng_dload_pkg.sv | 59 +++++
 rtl/jtgng_spi_shifter.sv | 76 +++++++
 rtl/jtgng_spi_dload_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_jtgng_spi_dload_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtgng_dload_pkg.sv
// ----------------------------------------------------------------------------
// jtgng_dload_pkg
// Shared definitions for the SPI download transmitter:
//   - loader command bytes (file index, file transfer begin/end, data)
//   - transaction selectors for the four-frame download sequence
//   - the download FSM state encoding
//   - helpers that map a transaction to its command and argument bytes
// No ports: package only.
// ----------------------------------------------------------------------------
package jtgng_dload_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
    localparam logic [7:0] TX_BEGIN        = 8'hFF;
    localparam logic [7:0] TX_END          = 8'h00;

    // Transaction order inside one download
    localparam logic [1:0] TR_INDEX = 2'd0;
    localparam logic [1:0] TR_BEGIN = 2'd1;
    localparam logic [1:0] TR_DAT   = 2'd2;
    localparam logic [1:0] TR_END   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEL   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DESEL = 3'd4,
        ST_GAP   = 3'd5,
        ST_FIN   = 3'd6
    } dload_state_t;

    // First byte of every SS2 frame
    function automatic logic [7:0] cmd_byte(input logic [1:0] trans);
        logic [7:0] b;
        case (trans)
            TR_INDEX: b = UIO_FILE_INDEX;
            TR_BEGIN: b = UIO_FILE_TX;
            TR_DAT:   b = UIO_FILE_TX_DAT;
            TR_END:   b = UIO_FILE_TX;
            default:  b = UIO_FILE_TX;
        endcase
        return b;
    endfunction

    // Second byte of the fixed-length frames; the data frame takes payload instead
    function automatic logic [7:0] arg_byte(input logic [1:0] trans, input logic [7:0] idx);
        logic [7:0] b;
        case (trans)
            TR_INDEX: b = idx;
            TR_BEGIN: b = TX_BEGIN;
            TR_END:   b = TX_END;
            default:  b = TX_END;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jtgng_spi_shifter.sv
// ----------------------------------------------------------------------------
// jtgng_spi_shifter
// 8-bit SPI mode-0 byte shifter, MSB first. A load while idle captures a byte
// and emits eight SCK pulses, each half-period lasting CLKDIV clk cycles.
// MOSI changes only at load and on SCK falling edges, so it is stable for the
// whole low half-period ahead of every rising edge.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   load, data  : start shifting 'data' (ignored while busy)
//   sck, mosi   : SPI clock (idles low) and data out
//   busy        : high from load until the eighth SCK falling edge
// ----------------------------------------------------------------------------
module jtgng_spi_shifter
    import jtgng_dload_pkg::*;
#(
    parameter int unsigned CLKDIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       sck,
    output logic       mosi,
    output logic       busy
);

    localparam logic [7:0] HALF_MAX = 8'(CLKDIV - 1);

    logic [7:0] sh_r;
    logic [7:0] div_r;
    logic [2:0] bit_r;
    logic       sck_r;
    logic       busy_r;

    // Half-period divider, SCK generation and MSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r   <= 8'h00;
            div_r  <= 8'd0;
            bit_r  <= 3'd0;
            sck_r  <= 1'b0;
            busy_r <= 1'b0;
        end else if (load && !busy_r) begin
            sh_r   <= data;
            div_r  <= 8'd0;
            bit_r  <= 3'd0;
            sck_r  <= 1'b0;
            busy_r <= 1'b1;
        end else if (busy_r) begin
            if (div_r == HALF_MAX) begin
                div_r <= 8'd0;
                if (!sck_r) begin
                    sck_r <= 1'b1;
                end else begin
                    sck_r <= 1'b0;
                    // Last bit stays on MOSI after the final fall
                    if (bit_r == 3'd7) begin
                        busy_r <= 1'b0;
                    end else begin
                        bit_r <= bit_r + 3'd1;
                        sh_r  <= {sh_r[6:0], 1'b0};
                    end
                end
            end else begin
                div_r <= div_r + 8'd1;
            end
        end else begin
            div_r <= 8'd0;
        end
    end

    assign sck  = sck_r;
    assign mosi = sh_r[7];
    assign busy = busy_r;

endmodule

// File: rtl/jtgng_spi_dload_tx.sv
// ----------------------------------------------------------------------------
// jtgng_spi_dload_tx
// Streams a file download to an SPI loader as four SS2-framed transactions:
//   55 index | 53 FF | 54 payload... | 53 00
// with SS2 held high for GAP cycles between frames.
// Ports:
//   clk_sys, rst_n            : system clock, async active-low reset
//   start, index              : begin a download for file 'index' (ignored while busy)
//   din, din_valid, din_last  : payload byte stream, din_last marks the final byte
//   din_ready                 : one-cycle pulse when din is consumed
//   spi_sck, spi_ss2, spi_di  : SPI mode-0 clock, active-low select, MOSI
//   busy, done                : download in progress / one-cycle completion pulse
//   byte_cnt                  : payload bytes sent, saturating
// ----------------------------------------------------------------------------
module jtgng_spi_dload_tx
    import jtgng_dload_pkg::*;
#(
    parameter int unsigned CLKDIV = 4,
    parameter int unsigned GAP    = 8,
    parameter int unsigned AW     = 22
) (
    input  logic          clk_sys,
    input  logic          rst_n,
    input  logic          start,
    input  logic [7:0]    index,
    input  logic [7:0]    din,
    input  logic          din_valid,
    input  logic          din_last,
    output logic          din_ready,
    output logic          spi_sck,
    output logic          spi_ss2,
    output logic          spi_di,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] byte_cnt
);

    localparam logic [7:0]    HALF_MAX = 8'(CLKDIV - 1);
    localparam logic [7:0]    GAP_MAX  = 8'(GAP - 1);
    localparam logic [AW-1:0] CNT_MAX  = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

    dload_state_t  state_r, state_s;
    logic [7:0]    tmr_r, tmr_s;
    logic [1:0]    trans_r, trans_s;
    logic          first_r, first_s;    // next byte of the frame is its command
    logic          last_r, last_s;      // the payload byte just loaded was the last
    logic [7:0]    index_r, index_s;
    logic          ss2_r, ss2_s;
    logic          busy_r, busy_s;
    logic          done_r, done_s;
    logic          ready_r, ready_s;
    logic [AW-1:0] cnt_r, cnt_s;
    logic          sh_load_s;
    logic [7:0]    sh_data_s;
    logic          sh_busy_s;

    jtgng_spi_shifter #(
        .CLKDIV (CLKDIV)
    ) u_shifter (
        .clk   (clk_sys),
        .rst_n (rst_n),
        .load  (sh_load_s),
        .data  (sh_data_s),
        .sck   (spi_sck),
        .mosi  (spi_di),
        .busy  (sh_busy_s)
    );

    // State and output registers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            tmr_r   <= 8'd0;
            trans_r <= TR_INDEX;
            first_r <= 1'b1;
            last_r  <= 1'b0;
            index_r <= 8'h00;
            ss2_r   <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            ready_r <= 1'b0;
            cnt_r   <= {AW{1'b0}};
        end else begin
            state_r <= state_s;
            tmr_r   <= tmr_s;
            trans_r <= trans_s;
            first_r <= first_s;
            last_r  <= last_s;
            index_r <= index_s;
            ss2_r   <= ss2_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
            ready_r <= ready_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: frame sequencing, payload handshake and SS2 timing
    always_comb begin
        state_s   = state_r;
        tmr_s     = tmr_r;
        trans_s   = trans_r;
        first_s   = first_r;
        last_s    = last_r;
        index_s   = index_r;
        ss2_s     = ss2_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        ready_s   = 1'b0;
        cnt_s     = cnt_r;
        sh_load_s = 1'b0;
        sh_data_s = 8'h00;
        case (state_r)
            ST_IDLE: begin
                // busy covers the done pulse, so a start coinciding with done is dropped
                if (done_r) begin
                    busy_s = 1'b0;
                end else begin
                    busy_s = busy_r;
                end
                if (start && !busy_r) begin
                    busy_s  = 1'b1;
                    index_s = index;
                    cnt_s   = {AW{1'b0}};
                    trans_s = TR_INDEX;
                    first_s = 1'b1;
                    last_s  = 1'b0;
                    tmr_s   = 8'd0;
                    ss2_s   = 1'b0;
                    state_s = ST_SEL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEL: begin
                // SS2 setup: one half-period before the command byte is loaded
                if (tmr_r == HALF_MAX && !sh_busy_s) begin
                    tmr_s     = 8'd0;
                    sh_load_s = 1'b1;
                    sh_data_s = cmd_byte(trans_r);
                    first_s   = 1'b1;
                    state_s   = ST_SHIFT;
                end else begin
                    tmr_s = tmr_r + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (!sh_busy_s) begin
                    state_s = ST_NEXT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_NEXT: begin
                if (trans_r == TR_DAT && (first_r || !last_r)) begin
                    // Registered din_ready: the byte is captured in the cycle the pulse is high
                    if (ready_r) begin
                        sh_load_s = 1'b1;
                        sh_data_s = din;
                        last_s    = din_last;
                        first_s   = 1'b0;
                        state_s   = ST_SHIFT;
                    end else if (din_valid) begin
                        ready_s = 1'b1;
                        if (cnt_r != CNT_MAX) begin
                            cnt_s = cnt_r + CNT_ONE;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end else begin
                        state_s = ST_NEXT;
                    end
                end else if (first_r) begin
                    sh_load_s = 1'b1;
                    sh_data_s = arg_byte(trans_r, index_r);
                    first_s   = 1'b0;
                    state_s   = ST_SHIFT;
                end else begin
                    tmr_s   = 8'd0;
                    state_s = ST_DESEL;
                end
            end
            ST_DESEL: begin
                if (tmr_r == HALF_MAX) begin
                    tmr_s   = 8'd0;
                    ss2_s   = 1'b1;
                    state_s = ST_GAP;
                end else begin
                    tmr_s = tmr_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (tmr_r == GAP_MAX) begin
                    tmr_s = 8'd0;
                    if (trans_r == TR_END) begin
                        state_s = ST_FIN;
                    end else begin
                        trans_s = trans_r + 2'd1;
                        first_s = 1'b1;
                        ss2_s   = 1'b0;
                        state_s = ST_SEL;
                    end
                end else begin
                    tmr_s = tmr_r + 8'd1;
                end
            end
            ST_FIN: begin
                done_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                ss2_s   = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign spi_ss2   = ss2_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign din_ready = ready_r;
    assign byte_cnt  = cnt_r;

endmodule

// File: tb/tb_jtgng_spi_dload_tx.sv
// ----------------------------------------------------------------------------
// tb_jtgng_spi_dload_tx
// Directed bench: expected SPI bytes and frame ends are queued when a download
// is started and popped by an SPI monitor that also drives a small loader
// model (index, downloading flag, address, memory).
// ----------------------------------------------------------------------------
module tb_jtgng_spi_dload_tx;

    localparam int CLKDIV = 2;
    localparam int GAP    = 4;
    localparam int AW     = 22;
    localparam logic [8:0] MARK = 9'h100;

    logic          clk_sys   = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic [7:0]    index     = 8'h00;
    logic [7:0]    din       = 8'h00;
    logic          din_valid = 1'b0;
    logic          din_last  = 1'b0;
    logic          din_ready;
    logic          spi_sck;
    logic          spi_ss2;
    logic          spi_di;
    logic          busy;
    logic          done;
    logic [AW-1:0] byte_cnt;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [7:0] pay_data_q[$];
    logic       pay_last_q[$];
    int         pay_hold_q[$];
    int hold_cnt = 0;
    int hold_win = 0;
    int hold_bad = 0;

    logic [7:0] mon_sh    = 8'h00;
    int         mon_bits  = 0;
    int         mon_frame = 0;
    int         done_cnt  = 0;
    int         done_base = 0;

    logic [7:0] ld_cmd   = 8'h00;
    logic [7:0] ld_index = 8'h00;
    logic       ld_dl    = 1'b0;
    int         ld_wr    = 0;
    int         ld_addr  = -1;
    logic [7:0] ld_mem[1024];

    jtgng_spi_dload_tx #(
        .CLKDIV (CLKDIV),
        .GAP    (GAP),
        .AW     (AW)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .start     (start),
        .index     (index),
        .din       (din),
        .din_valid (din_valid),
        .din_last  (din_last),
        .din_ready (din_ready),
        .spi_sck   (spi_sck),
        .spi_ss2   (spi_ss2),
        .spi_di    (spi_di),
        .busy      (busy),
        .done      (done),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_expect(input string tag, input logic [8:0] obs);
        logic [8:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(obs), 32'(e));
        end
    endtask

    // Loader model fed with each decoded byte
    task automatic on_byte(input logic [7:0] b, input int pos);
        sb_expect("spi_byte", {1'b0, b});
        if (pos == 0) begin
            ld_cmd = b;
        end else begin
            case (ld_cmd)
                8'h55: ld_index = b;
                8'h53: begin
                    if (b == 8'hFF) begin
                        ld_dl = 1'b1;
                        ld_wr = 0;
                    end else if (b == 8'h00) begin
                        ld_dl = 1'b0;
                    end
                end
                8'h54: begin
                    if (ld_dl) begin
                        ld_mem[ld_wr[9:0]] = b;
                        ld_addr = ld_wr;
                        ld_wr++;
                    end
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge spi_sck) begin
        mon_sh = {mon_sh[6:0], spi_di};
        mon_bits++;
        if (mon_bits % 8 == 0) on_byte(mon_sh, mon_bits / 8 - 1);
    end

    always @(posedge spi_ss2) begin
        if (rst_n === 1'b1) begin
            chk("frame_bits", 32'(mon_bits % 8), 32'd0);
            sb_expect("frame_end", MARK);
            mon_frame++;
        end
        mon_bits = 0;
    end

    always @(posedge clk_sys) begin
        if (done === 1'b1) done_cnt++;
    end

    // Upstream payload source: presents bytes after their hold delay, drops on din_ready
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!rst_n) begin
                din_valid = 1'b0;
                hold_cnt  = 0;
            end else if (!din_valid && pay_data_q.size() > 0) begin
                if (hold_cnt < pay_hold_q[0]) begin
                    if (hold_cnt >= 36) begin
                        hold_win++;
                        if (spi_ss2 !== 1'b0 || spi_sck !== 1'b0) hold_bad++;
                    end
                    hold_cnt++;
                end else begin
                    din       = pay_data_q[0];
                    din_last  = pay_last_q[0];
                    din_valid = 1'b1;
                end
            end
            @(posedge clk_sys);
            if (din_valid && din_ready === 1'b1) begin
                #1;
                din_valid = 1'b0;
                void'(pay_data_q.pop_front());
                void'(pay_last_q.pop_front());
                void'(pay_hold_q.pop_front());
                hold_cnt = 0;
            end
        end
    end

    task automatic add_pay(input logic [7:0] b, input logic last, input int hold);
        pay_data_q.push_back(b);
        pay_last_q.push_back(last);
        pay_hold_q.push_back(hold);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        exp_q.push_back(9'h055);
        exp_q.push_back({1'b0, idx});
        exp_q.push_back(MARK);
        exp_q.push_back(9'h053);
        exp_q.push_back(9'h0FF);
        exp_q.push_back(MARK);
        exp_q.push_back(9'h054);
        foreach (pay_data_q[i]) exp_q.push_back({1'b0, pay_data_q[i]});
        exp_q.push_back(MARK);
        exp_q.push_back(9'h053);
        exp_q.push_back(9'h000);
        exp_q.push_back(MARK);
        mon_frame = 0;
        done_base = done_cnt;
        @(negedge clk_sys);
        start = 1'b1;
        index = idx;
        @(negedge clk_sys);
        start = 1'b0;
        index = 8'h00;
    endtask

    task automatic finish_dl(input string tag, input int budget, input int exp_cnt);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (done_cnt != done_base) break;
        end
        repeat (40) @(negedge clk_sys);
        chk({tag, "_done"}, 32'(done_cnt - done_base), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_bytecnt"}, 32'(byte_cnt), 32'(exp_cnt));
        chk({tag, "_frames"}, 32'(mon_frame), 32'd4);
        chk({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_ss2"}, 32'(spi_ss2), 32'd1);
    endtask

    task automatic wait_pos(input string tag, input int frame, input int bits, input int budget);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            if (mon_frame == frame && mon_bits >= bits) begin
                reached = 1'b1;
                break;
            end
        end
        chk(tag, 32'(reached), 32'd1);
    endtask

    initial begin
        int mism;
        // Reset values
        repeat (3) @(negedge clk_sys);
        chk("rst_ss2", 32'(spi_ss2), 32'd1);
        chk("rst_sck", 32'(spi_sck), 32'd0);
        chk("rst_di", 32'(spi_di), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(din_ready), 32'd0);
        chk("rst_bytecnt", 32'(byte_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        // Basic download: 55 01 | 53 FF | 54 A5 3C | 53 00
        add_pay(8'hA5, 1'b0, 0);
        add_pay(8'h3C, 1'b1, 0);
        start_dl(8'h01);
        chk("a_busy_start", 32'(busy), 32'd1);
        finish_dl("a", 2000, 2);
        chk("a_ld_index", 32'(ld_index), 32'h01);
        chk("a_ld_dl", 32'(ld_dl), 32'd0);

        // Second byte withheld 50 cycles: link must idle with SS2 low, SCK low
        hold_win = 0;
        hold_bad = 0;
        add_pay(8'hA5, 1'b0, 0);
        add_pay(8'h3C, 1'b1, 50);
        start_dl(8'h01);
        finish_dl("b", 3000, 2);
        chk("b_hold_win", 32'(hold_win >= 10), 32'd1);
        chk("b_hold_bad", 32'(hold_bad), 32'd0);

        // Single payload byte flagged last
        add_pay(8'h80, 1'b1, 0);
        start_dl(8'h07);
        finish_dl("c", 2000, 1);

        // start during T3 must be dropped
        add_pay(8'h11, 1'b0, 0);
        add_pay(8'h22, 1'b0, 0);
        add_pay(8'h33, 1'b1, 0);
        start_dl(8'h03);
        wait_pos("d_reach_t3", 2, 12, 2000);
        @(negedge clk_sys);
        start = 1'b1;
        index = 8'h77;
        @(negedge clk_sys);
        start = 1'b0;
        index = 8'h00;
        finish_dl("d", 2000, 3);
        chk("d_ld_index", 32'(ld_index), 32'h03);

        // Reset during T3 aborts; the next start restarts at T1
        add_pay(8'hDE, 1'b0, 0);
        add_pay(8'hAD, 1'b1, 0);
        start_dl(8'h09);
        wait_pos("e_reach_t3", 2, 4, 2000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("e_rst_ss2", 32'(spi_ss2), 32'd1);
        chk("e_rst_sck", 32'(spi_sck), 32'd0);
        chk("e_rst_busy", 32'(busy), 32'd0);
        chk("e_rst_ready", 32'(din_ready), 32'd0);
        chk("e_rst_bytecnt", 32'(byte_cnt), 32'd0);
        exp_q.delete();
        pay_data_q.delete();
        pay_last_q.delete();
        pay_hold_q.delete();
        repeat (3) @(negedge clk_sys);
        chk("e_rst_di", 32'(spi_di), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        chk("e_idle_ss2", 32'(spi_ss2), 32'd1);
        add_pay(8'h5A, 1'b1, 0);
        start_dl(8'h02);
        finish_dl("e", 2000, 1);
        chk("e_ld_index", 32'(ld_index), 32'h02);

        // Loopback of 1024 bytes into the loader model
        for (int i = 0; i < 1024; i++) add_pay(8'(i), (i == 1023), 0);
        start_dl(8'h04);
        finish_dl("f", 60000, 1024);
        mism = 0;
        for (int i = 0; i < 1024; i++) begin
            if (ld_mem[i] !== 8'(i)) mism++;
        end
        chk("f_data", 32'(mism), 32'd0);
        chk("f_addr", 32'(ld_addr), 32'd1023);
        chk("f_wr", 32'(ld_wr), 32'd1024);
        chk("f_dl", 32'(ld_dl), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
